// File: rtl/dm_resp_pkg.sv
// Shared definitions for the data-memory responder: access-type encodings
// (common with the core's MEM stage), FSM state encodings and small decode helpers.
package dm_resp_pkg;

    // Access types as driven on DMType by the core.
    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    // Responder FSM states.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_MERGE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Encodings 101..111 are not defined and behave as a word access.
    function automatic logic [2:0] dm_norm(input logic [2:0] t);
        return (t > dm_byte_unsigned) ? dm_word : t;
    endfunction

    function automatic logic dm_is_half(input logic [2:0] t);
        return (t == dm_halfword) || (t == dm_halfword_unsigned);
    endfunction

    function automatic logic dm_is_byte(input logic [2:0] t);
        return (t == dm_byte) || (t == dm_byte_unsigned);
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Lane logic for the data-memory responder (combinational).
// Load path: picks the addressed byte/half out of the read word and extends it.
// Store path: splices the store lane into the read word for read-modify-write.
// dm_type is expected already normalised (101..111 folded to word).
module dm_lane
    import dm_resp_pkg::*;
(
    input  logic [2:0]  dm_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd_word,
    input  logic [15:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select and sign/zero extension of load data.
    always_comb begin
        byte_sel = rd_word[7:0];
        half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (byte_off)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        case (dm_type)
            dm_halfword:          ld_data = {{16{half_sel[15]}}, half_sel};
            dm_halfword_unsigned: ld_data = {16'h0000, half_sel};
            dm_byte:              ld_data = {{24{byte_sel[7]}}, byte_sel};
            dm_byte_unsigned:     ld_data = {24'h000000, byte_sel};
            default:              ld_data = rd_word;
        endcase
    end

    // Replace the addressed lane of the read word with the store lane.
    always_comb begin
        merged = rd_word;
        if (dm_is_byte(dm_type)) begin
            case (byte_off)
                2'd0:    merged[7:0]   = st_data[7:0];
                2'd1:    merged[15:8]  = st_data[7:0];
                2'd2:    merged[23:16] = st_data[7:0];
                default: merged[31:24] = st_data[7:0];
            endcase
        end else if (dm_is_half(dm_type)) begin
            if (byte_off[1]) merged[31:16] = st_data;
            else             merged[15:0]  = st_data;
        end
    end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: single-outstanding load/store engine in front of a
// word-organised synchronous-read array. Sub-word stores use read-modify-write.
// Build option DM_MISALIGN_TRAP_EN: misaligned requests are suppressed and
// flagged on misalign; otherwise low address bits are forced aligned.
//
// Handshake: a request is taken on a rising edge with req_valid && req_ready
// (req_ready is high only in IDLE); all request inputs are captured then and
// may change afterwards. rsp_valid is a one-cycle pulse (state RESP) and
// Data_out/misalign hold their values until the next pulse.
module dm_resp
    import dm_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic        rsp_valid,
    output logic [31:0] Data_out,
    output logic        misalign,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [1:0]        state;
    logic [31:0]       rd_word;
    logic [31:0]       data_q;
    logic [2:0]        cap_type;
    logic [1:0]        cap_off;
    logic [ADDR_W-1:0] cap_idx;
    logic [15:0]       cap_data;

    logic [2:0]        req_type;
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_idx;
    logic              req_bad;
    logic              accept;
    logic [31:0]       ld_data;
    logic [31:0]       merged;

    // Upper address bits are ignored, so addresses wrap modulo the array size.
    wire unused_addr = ^Addr_in[31:ADDR_W+2];

    assign req_type  = dm_norm(DMType);
    assign req_idx   = Addr_in[ADDR_W+1:2];
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready && !reset;
    assign Data_out  = data_q;
    assign dbg_state = state;

`ifdef DM_MISALIGN_TRAP_EN
    logic misalign_q;
    assign req_bad  = ((req_type == dm_word) && (Addr_in[1:0] != 2'b00)) ||
                      (dm_is_half(req_type) && Addr_in[0]);
    assign misalign = misalign_q;
`else
    assign req_bad  = 1'b0;
    assign misalign = 1'b0;
`endif

    // Byte offset within the word, with alignment forced by access size.
    always_comb begin
        req_off = Addr_in[1:0];
        if (req_type == dm_word)       req_off = 2'b00;
        else if (dm_is_half(req_type)) req_off = {Addr_in[1], 1'b0};
    end

    dm_lane u_lane (
        .dm_type  (cap_type),
        .byte_off (cap_off),
        .rd_word  (rd_word),
        .st_data  (cap_data),
        .ld_data  (ld_data),
        .merged   (merged)
    );

    // Array port: read on acceptance, word store at acceptance, merge write in MERGE.
    always_ff @(posedge clk) begin
        if (accept && !req_bad) begin
            rd_word <= mem[req_idx];
            if (mem_w && (req_type == dm_word)) mem[req_idx] <= Data_in;
        end else if ((state == S_MERGE) && !reset) begin
            mem[cap_idx] <= merged;
        end
    end

    // Capture the request so the requester may move on after acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_type <= req_type;
            cap_off  <= req_off;
            cap_idx  <= req_idx;
            cap_data <= Data_in[15:0];
        end
    end

    // Responder FSM; Data_out only changes when entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            data_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (req_bad) begin
                            state  <= S_RESP;
                            data_q <= 32'h0;
                        end else if (!mem_w) begin
                            state <= S_LOAD;
                        end else if (req_type == dm_word) begin
                            state  <= S_RESP;
                            data_q <= 32'h0;
                        end else begin
                            state <= S_MERGE;
                        end
                    end
                end
                S_LOAD: begin
                    data_q <= ld_data;
                    state  <= S_RESP;
                end
                S_MERGE: begin
                    data_q <= 32'h0;
                    state  <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DM_MISALIGN_TRAP_EN
    // Misalign flag, updated together with Data_out on entry to RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (accept && (req_bad || (mem_w && (req_type == dm_word)))) begin
            misalign_q <= req_bad;
        end else if ((state == S_LOAD) || (state == S_MERGE)) begin
            misalign_q <= 1'b0;
        end
    end
`endif

endmodule
